// File: rtl/ofm_wr_arbiter.sv
// Round-robin arbiter that drains OFM requesters into the next-layer RAM
// in fixed-length write bursts with an auto-incrementing write address.
module ofm_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic                        ram_ready,
  input  logic                        cfg_addr_load,
  input  logic [ADDR_W-1:0]           cfg_base_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        beat,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        burst_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [IDX_W-1:0]   win_idx, win_idx_nx;
  logic [IDX_W-1:0]   pick_idx, cand;
  logic               pick_vld;
  logic [NUM_REQ-1:0] gnt_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               done_nx;
  logic               last_beat;

  // First requesting index at or above rr_ptr, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign beat      = (state == BURST) && ram_ready;
  assign wr_en     = beat;
  assign wr_data   = (state == BURST) ? req_data[win_idx*DATA_W +: DATA_W] : '0;
  assign last_beat = (cnt == CNT_W'(BURST_LEN - 1));

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    win_idx_nx = win_idx;
    rr_ptr_nx  = rr_ptr;
    cnt_nx     = cnt;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        gnt_nx = '0;
        if (pick_vld) begin
          state_nx   = BURST;
          gnt_nx     = NUM_REQ'(1) << pick_idx;
          win_idx_nx = pick_idx;
          cnt_nx     = '0;
        end
      end
      BURST: begin
        if (beat) begin
          if (last_beat) begin
            state_nx  = IDLE;
            gnt_nx    = '0;
            cnt_nx    = '0;
            done_nx   = 1'b1;
            rr_ptr_nx = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      win_idx    <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nx;
      gnt        <= gnt_nx;
      win_idx    <= win_idx_nx;
      rr_ptr     <= rr_ptr_nx;
      cnt        <= cnt_nx;
      burst_done <= done_nx;
    end
  end

  // Address load wins over a coincident beat increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (cfg_addr_load) begin
      wr_addr <= cfg_base_addr;
    end else if (beat) begin
      wr_addr <= wr_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_ofm_wr_arbiter.sv
// Directed plus randomized bench for ofm_wr_arbiter against a burst-level
// reference model (owner / beats-remaining / pointer / address).
module tb_ofm_wr_arbiter;

  localparam int N  = 4;
  localparam int BL = 4;
  localparam int DW = 64;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            ram_ready;
  logic            cfg_addr_load;
  logic [AW-1:0]   cfg_base_addr;
  logic [N-1:0]    gnt;
  logic            beat;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            burst_done;

  always #5 clk = ~clk;

  ofm_wr_arbiter #(
    .NUM_REQ  (N),
    .BURST_LEN(BL),
    .DATA_W   (DW),
    .ADDR_W   (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ram_ready    (ram_ready),
    .cfg_addr_load(cfg_addr_load),
    .cfg_base_addr(cfg_base_addr),
    .gnt          (gnt),
    .beat         (beat),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .burst_done   (burst_done)
  );

  int tests = 0;
  int fails = 0;

  // Reference: owner = -1 when no burst is in progress.
  int            m_owner;
  int            m_left;
  int            m_ptr;
  logic [AW-1:0] m_addr;
  logic          m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_ptr   = 0;
    m_addr  = '0;
    m_done  = 1'b0;
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic rdy,
                      input logic ld, input logic [AW-1:0] base);
    logic [N-1:0]  eg;
    logic          eb;
    logic [DW-1:0] ed;
    @(negedge clk);
    rst           = r;
    req           = rq;
    ram_ready     = rdy;
    cfg_addr_load = ld;
    cfg_base_addr = base;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
    if (r) model_reset();
    #1;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    eb = (m_owner >= 0) && rdy;
    ed = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : '0;
    check("gnt",        64'(gnt),        64'(eg));
    check("beat",       64'(beat),       64'(eb));
    check("wr_en",      64'(wr_en),      64'(eb));
    check("wr_data",    64'(wr_data),    64'(ed));
    check("wr_addr",    64'(wr_addr),    64'(m_addr));
    check("burst_done", 64'(burst_done), 64'(m_done));
    @(posedge clk);
    if (!r) begin
      m_done = 1'b0;
      if (ld) m_addr = base;
      else if (eb) m_addr = m_addr + 1;
      if (m_owner >= 0) begin
        if (rdy) begin
          m_left--;
          if (m_left == 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_done  = 1'b1;
          end
        end
      end else if (rq != '0) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_left = BL;
      end
    end
  endtask

  initial begin
    logic [N-1:0]  rq;
    logic          rdy, ld, r;
    logic [AW-1:0] base;
    rst = 1'b1; req = '0; ram_ready = 1'b0; cfg_addr_load = 1'b0;
    cfg_base_addr = '0; req_data = '0;
    model_reset();

    repeat (2) step(1, '0, 1, 0, '0);

    // Single requester 1, full-rate burst.
    repeat (7) step(0, 4'b0010, 1, 0, '0);

    // All requesting: rotation 0,1,2,3,0 with continuous addresses.
    step(1, '0, 0, 0, '0);
    repeat (26) step(0, 4'b1111, 1, 0, '0);

    // Stall after beat 2; req dropped after grant must not abort the burst.
    step(1, '0, 0, 0, '0);
    step(0, 4'b0001, 1, 0, '0);
    repeat (2) step(0, '0, 1, 0, '0);
    repeat (3) step(0, '0, 0, 0, '0);
    repeat (4) step(0, '0, 1, 0, '0);

    // Address load coincident with a beat, then wrap at all-ones.
    step(1, '0, 0, 0, '0);
    step(0, '0, 0, 1, 32'd5);
    step(0, 4'b0001, 1, 0, '0);
    step(0, '0, 1, 1, 32'h100);
    repeat (4) step(0, '0, 1, 0, '0);
    step(0, '0, 0, 1, 32'hFFFF_FFFF);
    step(0, 4'b0001, 1, 0, '0);
    repeat (5) step(0, '0, 1, 0, '0);

    // Reset during beat 2 of a burst to requester 2; restart from index 0.
    step(1, '0, 0, 0, '0);
    step(0, 4'b0100, 1, 0, '0);
    step(0, '0, 1, 0, '0);
    step(1, '0, 1, 0, '0);
    repeat (8) step(0, 4'b0110, 1, 0, '0);

    // Randomized traffic.
    step(1, '0, 0, 0, '0);
    repeat (400) begin
      rq   = N'($urandom);
      rdy  = ($urandom_range(0, 9) < 7);
      ld   = ($urandom_range(0, 19) == 0);
      r    = ($urandom_range(0, 99) == 0);
      base = $urandom;
      if ($urandom_range(0, 9) == 0) base = 32'hFFFF_FFFE;
      step(r, rq, rdy, ld, base);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
